// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: one neuron at a time, one signed MAC per cycle.
// The input vector is latched on start; weights stream row-major; results leave over valid/ready.
module fc_layer_seq #(
    parameter int WORD_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int IN_SIZE   = 120,
    parameter int OUT_SIZE  = 84,
    parameter int RELU      = 0
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start,
    input  logic [WORD_SIZE*IN_SIZE-1:0]                         X,
    input  logic [WORD_SIZE*OUT_SIZE-1:0]                        B,
    input  logic                                                 w_valid,
    input  logic [WORD_SIZE-1:0]                                 w_data,
    output logic                                                 w_ready,
    output logic                                                 z_valid,
    output logic [WORD_SIZE-1:0]                                 z_data,
    output logic [(OUT_SIZE > 1 ? $clog2(OUT_SIZE) : 1)-1:0]     z_index,
    input  logic                                                 z_ready,
    output logic                                                 busy,
    output logic                                                 done
);

    localparam int ACC_W = 2*WORD_SIZE + $clog2(IN_SIZE) + 1;
    localparam int COL_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int IDX_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam logic signed [ACC_W-1:0] ZMAX = {{(ACC_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ZMIN = {{(ACC_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MAC, FINAL, OUT, DONE} state_t;

    state_t                        state, state_nxt;
    logic signed [ACC_W-1:0]       acc;
    logic        [COL_W-1:0]       col;
    logic        [IDX_W-1:0]       row;
    logic signed [WORD_SIZE-1:0]   x_buf [IN_SIZE];
    logic signed [WORD_SIZE-1:0]   b_arr [OUT_SIZE];
    logic signed [2*WORD_SIZE-1:0] x_ext, w_ext, prod;
    logic signed [ACC_W-1:0]       prod_ext, bias_ext;
    logic signed [WORD_SIZE-1:0]   result;
    logic                          last_col, last_row;

    // Arithmetic shift right: floor toward minus infinity.
    function automatic logic signed [ACC_W-1:0] floor_shift(input logic signed [ACC_W-1:0] v);
        return v >>> FRAC_BITS;
    endfunction

    function automatic logic signed [WORD_SIZE-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > ZMAX)
            return ZMAX[WORD_SIZE-1:0];
        else if (v < ZMIN)
            return ZMIN[WORD_SIZE-1:0];
        else
            return v[WORD_SIZE-1:0];
    endfunction

    function automatic logic signed [WORD_SIZE-1:0] relu_clamp(input logic signed [WORD_SIZE-1:0] r);
        return (RELU != 0 && r[WORD_SIZE-1]) ? '0 : r;
    endfunction

    always_comb begin
        for (int i = 0; i < OUT_SIZE; i++)
            b_arr[i] = B[i*WORD_SIZE +: WORD_SIZE];
    end

    // Full-precision product, sign-extended into the accumulator width.
    assign x_ext    = {{WORD_SIZE{x_buf[col][WORD_SIZE-1]}}, x_buf[col]};
    assign w_ext    = {{WORD_SIZE{w_data[WORD_SIZE-1]}}, w_data};
    assign prod     = x_ext * w_ext;
    assign prod_ext = {{(ACC_W-2*WORD_SIZE){prod[2*WORD_SIZE-1]}}, prod};
    assign bias_ext = $signed({{(ACC_W-WORD_SIZE){b_arr[row][WORD_SIZE-1]}}, b_arr[row]}) <<< FRAC_BITS;
    assign result   = relu_clamp(saturate(floor_shift(acc + bias_ext)));

    assign last_col = (col == COL_W'(IN_SIZE-1));
    assign last_row = (row == IDX_W'(OUT_SIZE-1));

    assign w_ready = (state == MAC);
    assign z_valid = (state == OUT);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (w_valid && last_col) state_nxt = FINAL;
            FINAL:   state_nxt = OUT;
            OUT:     if (z_ready) state_nxt = last_row ? DONE : MAC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            col     <= '0;
            row     <= '0;
            z_data  <= '0;
            z_index <= '0;
            for (int i = 0; i < IN_SIZE; i++)
                x_buf[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < IN_SIZE; i++)
                            x_buf[i] <= X[i*WORD_SIZE +: WORD_SIZE];
                        acc <= '0;
                        col <= '0;
                        row <= '0;
                    end
                end
                MAC: begin
                    if (w_valid) begin
                        acc <= acc + prod_ext;
                        col <= last_col ? '0 : col + COL_W'(1);
                    end
                end
                FINAL: begin
                    z_data  <= result;
                    z_index <= row;
                end
                OUT: begin
                    if (z_ready) begin
                        acc <= '0;
                        if (!last_row) row <= row + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Randomised bench for fc_layer_seq: two instances (RELU=0 and RELU=1) share stimulus and are
// checked every cycle against a plain-arithmetic model of the layer.
module tb_fc_layer_seq;

    localparam int W  = 16;
    localparam int F  = 8;
    localparam int NI = 4;
    localparam int NO = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [W*NI-1:0] X = '0;
    logic [W*NO-1:0] B = '0;
    logic            w_valid = 1'b0;
    logic [W-1:0]    w_data = '0;
    logic            z_ready = 1'b0;

    logic         w_ready_a, z_valid_a, busy_a, done_a;
    logic [W-1:0] z_data_a;
    logic [0:0]   z_index_a;
    logic         w_ready_b, z_valid_b, busy_b, done_b;
    logic [W-1:0] z_data_b;
    logic [0:0]   z_index_b;

    always #5 clk = ~clk;

    fc_layer_seq #(.WORD_SIZE(W), .FRAC_BITS(F), .IN_SIZE(NI), .OUT_SIZE(NO), .RELU(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .X(X), .B(B),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready_a),
        .z_valid(z_valid_a), .z_data(z_data_a), .z_index(z_index_a), .z_ready(z_ready),
        .busy(busy_a), .done(done_a));

    fc_layer_seq #(.WORD_SIZE(W), .FRAC_BITS(F), .IN_SIZE(NI), .OUT_SIZE(NO), .RELU(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .X(X), .B(B),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready_b),
        .z_valid(z_valid_b), .z_data(z_data_b), .z_index(z_index_b), .z_ready(z_ready),
        .busy(busy_b), .done(done_b));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mx [NI];
    int mw [NO][NI];
    int mb [NO];
    int exp0 [NO];
    int exp1 [NO];
    int res_a [NO];
    int res_b [NO];
    int base [NO];
    int nres = 0, widx = 0, ndone = 0, first_zv = -1, done_cyc = -1;
    int gap_pct = 0, zhold_init = 0, zhold_cnt = 0, zrand = 0;
    bit feeding = 1'b0, req_abort = 1'b0, prev_stall = 1'b0;
    logic [W-1:0] prev_z = '0;

    task automatic chk(input string name, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Dot product + scaled bias, floor shift, saturate, optional ReLU.
    function automatic int model_z(input int r, input int relu);
        longint s = 0;
        for (int c = 0; c < NI; c++)
            s += longint'(mx[c]) * longint'(mw[r][c]);
        s += longint'(mb[r]) * (longint'(1) << F);
        s = s >>> F;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu != 0 && s < 0) s = 0;
        return int'(s);
    endfunction

    task automatic fill_rand(input bit big);
        for (int c = 0; c < NI; c++)
            mx[c] = big ? int'($signed(16'($urandom))) : int'($urandom_range(1023)) - 512;
        for (int r = 0; r < NO; r++) begin
            mb[r] = big ? int'($signed(16'($urandom))) : int'($urandom_range(1023)) - 512;
            for (int c = 0; c < NI; c++)
                mw[r][c] = big ? int'($signed(16'($urandom))) : int'($urandom_range(1023)) - 512;
        end
    endtask

    // One clock: check outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic cycle();
        bit new_res;
        @(negedge clk);
        cyc++;
        if (rst) begin
            chk("rst_w_ready", w_ready_a, 0);  chk("rst_w_ready_b", w_ready_b, 0);
            chk("rst_z_valid", z_valid_a, 0);  chk("rst_z_valid_b", z_valid_b, 0);
            chk("rst_z_data", z_data_a, 0);    chk("rst_z_data_b", z_data_b, 0);
            chk("rst_z_index", z_index_a, 0);  chk("rst_busy", busy_a, 0);
            chk("rst_busy_b", busy_b, 0);      chk("rst_done", done_a, 0);
            rst = 1'b0;
        end
        chk("ab_z_valid", z_valid_b, z_valid_a);
        chk("ab_w_ready", w_ready_b, w_ready_a);
        chk("ab_busy", busy_b, busy_a);
        chk("ab_done", done_b, done_a);
        if (prev_stall) begin
            chk("stall_z_valid", z_valid_a, 1);
            chk("stall_z_data", z_data_a, prev_z);
        end
        if (z_valid_a) begin
            if (first_zv < 0) first_zv = cyc;
            chk("w_ready_in_out", w_ready_a, 0);
            if (nres < NO) begin
                chk("z_index", z_index_a, nres);
                chk("z_data_relu0", int'($signed(z_data_a)), exp0[nres]);
                chk("z_data_relu1", int'($signed(z_data_b)), exp1[nres]);
            end else begin
                chk("extra_result", nres, NO - 1);
            end
        end
        if (done_a) begin
            ndone++;
            done_cyc = cyc;
            chk("done_after_all_results", nres, NO);
        end
        if (req_abort) begin
            rst = 1'b1;
            feeding = 1'b0;
            req_abort = 1'b0;
            w_valid = 1'b0;
            z_ready = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (feeding && widx < NI*NO) begin
                w_valid = ($urandom_range(99) >= gap_pct);
                w_data  = 16'(mw[widx / NI][widx % NI]);
            end else begin
                w_valid = 1'b0;
                w_data  = 16'($urandom);
            end
            if (w_valid && w_ready_a) widx++;
            new_res = z_valid_a && !prev_stall;
            if (new_res) zhold_cnt = zhold_init;
            if (zhold_cnt > 0) begin
                z_ready = 1'b0;
                zhold_cnt--;
            end else begin
                z_ready = (zrand != 0) ? 1'($urandom_range(1)) : 1'b1;
            end
            if (z_valid_a && z_ready && nres < NO) begin
                res_a[nres] = int'($signed(z_data_a));
                res_b[nres] = int'($signed(z_data_b));
                nres++;
            end
            prev_stall = z_valid_a && !z_ready;
            prev_z = z_data_a;
        end
    endtask

    task automatic load_pass(input int gap, input int zr, input int zh);
        for (int c = 0; c < NI; c++) X[c*W +: W] = 16'(mx[c]);
        for (int r = 0; r < NO; r++) begin
            B[r*W +: W] = 16'(mb[r]);
            exp0[r] = model_z(r, 0);
            exp1[r] = model_z(r, 1);
        end
        nres = 0; widx = 0; ndone = 0; first_zv = -1; done_cyc = -1;
        gap_pct = gap; zrand = zr; zhold_init = zh; zhold_cnt = 0;
        feeding = 1'b1;
    endtask

    task automatic run_pass(input int gap, input int zr, input int zh, input bit ign, output int s);
        load_pass(gap, zr, zh);
        start = 1'b1;
        s = cyc;
        cycle();
        start = 1'b0;
        chk("busy_after_start", busy_a, 1);
        chk("w_ready_after_start", w_ready_a, 1);
        for (int k = 0; k < 3000 && ndone == 0; k++) begin
            if (ign && cyc == s + 3) begin
                X = ~X;
                start = 1'b1;
            end else if (ign && first_zv >= 0 && cyc == first_zv) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            cycle();
        end
        start = 1'b0;
        chk("done_seen", ndone, 1);
        repeat (4) cycle();
        chk("single_done", ndone, 1);
        chk("results_count", nres, NO);
        feeding = 1'b0;
    endtask

    initial begin
        int s;
        cycle();
        cycle();

        // Basic: 4 * (1.0 * 0.5) + 0.25 = 2.25
        for (int c = 0; c < NI; c++) begin mx[c] = 256; mw[0][c] = 128; mw[1][c] = int'($urandom_range(511)) - 256; end
        mb[0] = 64; mb[1] = 100;
        chk("model_basic", model_z(0, 0), 576);
        run_pass(0, 0, 0, 1'b0, s);
        chk("basic_z", res_a[0], 576);
        chk("basic_first_z_valid", first_zv - s, NI + 2);
        chk("basic_done_cycle", done_cyc - s, 1 + NO*(NI + 2));

        // Floor rounding
        for (int c = 0; c < NI; c++) begin mx[c] = 1; mw[0][c] = 1; mw[1][c] = -1; end
        mb[0] = 0; mb[1] = 0;
        chk("model_floor_neg", model_z(1, 0), -1);
        run_pass(0, 1, 0, 1'b0, s);
        chk("floor_pos_z", res_a[0], 0);
        chk("floor_neg_z", res_a[1], -1);

        // Saturation and ReLU
        for (int c = 0; c < NI; c++) begin mx[c] = 32512; mw[0][c] = 32512; mw[1][c] = -32512; end
        mb[0] = 0; mb[1] = 0;
        chk("model_sat_neg", model_z(1, 0), -32768);
        run_pass(20, 1, 0, 1'b0, s);
        chk("sat_pos_z", res_a[0], 32767);
        chk("sat_neg_z", res_a[1], -32768);
        chk("sat_pos_relu_z", res_b[0], 32767);
        chk("sat_neg_relu_z", res_b[1], 0);

        // Back-pressure: same data unstalled, then with weight gaps and a 10-cycle z hold
        fill_rand(1'b0);
        run_pass(0, 0, 0, 1'b0, s);
        for (int r = 0; r < NO; r++) base[r] = res_a[r];
        run_pass(40, 0, 10, 1'b0, s);
        for (int r = 0; r < NO; r++) chk("stalled_equals_unstalled", res_a[r], base[r]);

        // Reset during MAC of row 1, then a clean pass
        fill_rand(1'b1);
        load_pass(0, 0, 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 200 && widx < NI + 1; k++) cycle();
        chk("abort_in_row1_mac", int'(widx >= NI + 1), 1);
        chk("abort_state_mac", w_ready_a, 1);
        req_abort = 1'b1;
        cycle();
        cycle();
        chk("abort_no_done", ndone, 0);
        fill_rand(1'b0);
        run_pass(30, 1, 0, 1'b0, s);

        // Start pulses in MAC and OUT with a different X must be ignored
        fill_rand(1'b0);
        run_pass(0, 0, 3, 1'b1, s);

        for (int it = 0; it < 6; it++) begin
            fill_rand(it[0]);
            run_pass(int'($urandom_range(60)), 1, int'($urandom_range(4)), 1'b0, s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
